// File: rtl/graphite_cmd_pkg.sv
// Shared definitions for the Graphite command streamer: register map,
// STATUS/CONTROL bit positions and the STATUS word packer.
package graphite_cmd_pkg;

  typedef enum logic [1:0] {
    REG_CMD_DATA = 2'd0,
    REG_STATUS   = 2'd1,
    REG_CONTROL  = 2'd2,
    REG_RESERVED = 2'd3
  } reg_idx_e;

  // STATUS register layout
  localparam int unsigned ST_LEVEL_W   = 16;
  localparam int unsigned ST_EMPTY_BIT = 16;
  localparam int unsigned ST_FULL_BIT  = 17;
  localparam int unsigned ST_OVF_BIT   = 18;
  localparam int unsigned ST_IRQ_BIT   = 19;

  // CONTROL register layout
  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_OVF_CLR_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 2;

  function automatic logic [31:0] pack_status(
    input logic [ST_LEVEL_W-1:0] level,
    input logic                  empty,
    input logic                  full,
    input logic                  ovf,
    input logic                  irq
  );
    logic [31:0] w_word;
    w_word                  = '0;
    w_word[ST_LEVEL_W-1:0]  = level;
    w_word[ST_EMPTY_BIT]    = empty;
    w_word[ST_FULL_BIT]     = full;
    w_word[ST_OVF_BIT]      = ovf;
    w_word[ST_IRQ_BIT]      = irq;
    return w_word;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO with level output and a flush that can keep the
// head word alive while it is still being offered downstream.
module cmd_fifo
  import graphite_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     keep_head_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [DW-1:0]            head_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW:0]   w_rd_next;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = pop_i && !w_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push_ok = push_i && (!w_full || w_pop_ok);
  assign w_rd_next = r_rd_ptr + (w_pop_ok ? ONE : '0);

  assign level_o = r_wr_ptr - r_rd_ptr;
  assign empty_o = w_empty;
  assign full_o  = w_full;
  assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush collapses the write pointer onto the read side,
  // leaving exactly one word when the head must stay on offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= keep_head_i ? (w_rd_next + ONE) : w_rd_next;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
    end
  end

  // Storage array; cleared on reset so the head output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/graphite_cmd_streamer.sv
// CPU register-bus front end for the Graphite command stream: bus decode,
// one-cycle ack, sticky overflow, irq enable/low-water interrupt, and the
// command FIFO feeding the cmd_axis master.
module graphite_cmd_streamer
  import graphite_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOW_WATER  = 4
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        cmd_axis_tvalid_o,
  input  logic        cmd_axis_tready_i,
  output logic [31:0] cmd_axis_tdata_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LW = (AW+1)'(LOW_WATER);

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_ovf;
  logic        r_irq_en;
  logic        r_irq;

  reg_idx_e    w_addr;
  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_keep;
  logic        w_ctrl_wr;
  logic        w_ovf_set;
  logic        w_empty;
  logic        w_full;
  logic [AW:0] w_level;
  logic [31:0] w_head;
  logic [31:0] w_rd_mux;

  assign w_addr    = reg_idx_e'(addr_i);
  assign w_req     = sel_i && !r_ack;
  assign w_wr      = w_req && wr_i;
  assign w_rd      = w_req && !wr_i;
  assign w_push    = w_wr && (w_addr == REG_CMD_DATA);
  assign w_ctrl_wr = w_wr && (w_addr == REG_CONTROL);
  assign w_flush   = w_ctrl_wr && data_i[CTRL_FLUSH_BIT];
  assign w_pop     = !w_empty && cmd_axis_tready_i;
  // Head is mid-offer without acceptance: flushing it would retract tvalid.
  assign w_keep    = !w_empty && !cmd_axis_tready_i;
  assign w_ovf_set = w_push && w_full && !w_pop;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (32)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n_i),
    .push_i      (w_push),
    .push_data_i (data_i),
    .pop_i       (w_pop),
    .flush_i     (w_flush),
    .keep_head_i (w_keep),
    .level_o     (w_level),
    .empty_o     (w_empty),
    .full_o      (w_full),
    .head_o      (w_head)
  );

  // Read data mux, built from pre-edge state.
  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      REG_STATUS:  w_rd_mux = pack_status(ST_LEVEL_W'(w_level), w_empty, w_full, r_ovf, r_irq);
      REG_CONTROL: w_rd_mux[CTRL_IRQ_EN_BIT] = r_irq_en;
      default:     w_rd_mux = '0;
    endcase
  end

  // Bus acknowledge and registered read data for the accepted request.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rd ? w_rd_mux : '0;
    end
  end

  // Sticky overflow and persistent irq enable.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ctrl_wr && data_i[CTRL_OVF_CLR_BIT]) begin
        r_ovf <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_irq_en <= data_i[CTRL_IRQ_EN_BIT];
      end
    end
  end

  // Low-water interrupt, registered one cycle behind level/enable.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en && (w_level <= LW);
    end
  end

  assign ack_o             = r_ack;
  assign data_o            = r_rdata;
  assign cmd_axis_tvalid_o = !w_empty;
  assign cmd_axis_tdata_o  = w_head;
  assign irq_o             = r_irq;

endmodule

// File: tb/tb_graphite_cmd_streamer.sv
// Directed bench for graphite_cmd_streamer: a register-access vector table
// followed by hand-written multi-cycle sequences.
module tb_graphite_cmd_streamer;
  import graphite_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        sel_i;
  logic        wr_i;
  logic [1:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        cmd_axis_tvalid_o;
  logic        cmd_axis_tready_i;
  logic [31:0] cmd_axis_tdata_o;
  logic        irq_o;

  always #5 clk = ~clk;

  graphite_cmd_streamer #(
    .FIFO_DEPTH (16),
    .LOW_WATER  (4)
  ) dut (
    .clk               (clk),
    .reset_n_i         (reset_n_i),
    .sel_i             (sel_i),
    .wr_i              (wr_i),
    .addr_i            (addr_i),
    .data_i            (data_i),
    .data_o            (data_o),
    .ack_o             (ack_o),
    .cmd_axis_tvalid_o (cmd_axis_tvalid_o),
    .cmd_axis_tready_i (cmd_axis_tready_i),
    .cmd_axis_tdata_o  (cmd_axis_tdata_o),
    .irq_o             (irq_o)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        trdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_tvalid;
    logic [31:0] exp_tdata;
  } vec_t;

  vec_t        vecs [18];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One bus transaction: request at a falling edge, taken on the next rising
  // edge, result sampled at the following falling edge while ack is high.
  task automatic bus_op(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                        input logic trdy, output logic [31:0] rdata);
    @(negedge clk);
    sel_i = 1'b1; wr_i = wr; addr_i = addr; data_i = wdata; cmd_axis_tready_i = trdy;
    @(negedge clk);
    chk("ack", {31'b0, ack_o}, 32'd1);
    rdata = data_o;
    sel_i = 1'b0; wr_i = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [31:0] wdata);
    logic [31:0] unused;
    bus_op(1'b1, addr, wdata, 1'b0, unused);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    bus_op(1'b0, addr, 32'h0, 1'b0, r);
    chk(name, r, exp);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; sel_i = 1'b0; wr_i = 1'b0; addr_i = 2'd0; data_i = 32'h0;
    cmd_axis_tready_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, REG_STATUS,   32'h0,         1'b0, 1'b1, 32'h0001_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, REG_CONTROL,  32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b0, REG_RESERVED, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[3]  = '{1'b1, REG_CMD_DATA, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    vecs[4]  = '{1'b1, REG_CMD_DATA, 32'h2222_2222, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    vecs[5]  = '{1'b0, REG_STATUS,   32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 32'h1111_1111};
    vecs[6]  = '{1'b0, REG_CMD_DATA, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'h1111_1111};
    vecs[7]  = '{1'b1, REG_STATUS,   32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    vecs[8]  = '{1'b0, REG_STATUS,   32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 32'h1111_1111};
    vecs[9]  = '{1'b1, REG_RESERVED, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    vecs[10] = '{1'b1, REG_CONTROL,  32'h0000_0004, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    vecs[11] = '{1'b0, REG_CONTROL,  32'h0,         1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h1111_1111};
    vecs[12] = '{1'b0, REG_STATUS,   32'h0,         1'b0, 1'b1, 32'h0008_0002, 1'b1, 32'h1111_1111};
    vecs[13] = '{1'b1, REG_CONTROL,  32'h0000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    vecs[14] = '{1'b0, REG_STATUS,   32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 32'h1111_1111};
    vecs[15] = '{1'b1, REG_CONTROL,  32'h0000_0001, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    vecs[16] = '{1'b0, REG_STATUS,   32'h0,         1'b0, 1'b1, 32'h0000_0001, 1'b1, 32'h1111_1111};
    vecs[17] = '{1'b0, REG_STATUS,   32'h0,         1'b1, 1'b1, 32'h0000_0001, 1'b0, 32'h0};

    // Reset values
    reset_n_i = 1'b0; sel_i = 1'b0; wr_i = 1'b0; addr_i = 2'd0; data_i = 32'h0;
    cmd_axis_tready_i = 1'b0;
    #3;
    chk("rst_ack",    {31'b0, ack_o},             32'd0);
    chk("rst_data",   data_o,                     32'd0);
    chk("rst_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd0);
    chk("rst_tdata",  cmd_axis_tdata_o,           32'd0);
    chk("rst_irq",    {31'b0, irq_o},             32'd0);
    do_reset();

    // Register access table
    for (int i = 0; i < 18; i++) begin
      bus_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].trdy, d);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
      chk($sformatf("vec%0d_tvalid", i), {31'b0, cmd_axis_tvalid_o}, {31'b0, vecs[i].exp_tvalid});
      if (vecs[i].exp_tvalid) chk($sformatf("vec%0d_tdata", i), cmd_axis_tdata_o, vecs[i].exp_tdata);
    end
    cmd_axis_tready_i = 1'b0;

    // A: single word held under backpressure, then one pop
    do_reset();
    wr_reg(REG_CMD_DATA, 32'hA5A5_0001);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("A_hold%0d_tvalid", i), {31'b0, cmd_axis_tvalid_o}, 32'd1);
      chk($sformatf("A_hold%0d_tdata", i), cmd_axis_tdata_o, 32'hA5A5_0001);
      @(negedge clk);
    end
    cmd_axis_tready_i = 1'b1;
    @(negedge clk);
    chk("A_popped_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd0);
    cmd_axis_tready_i = 1'b0;
    rd_chk("A_status", REG_STATUS, 32'h0001_0000);

    // B: fill, overflow, stream out in order, clear overflow
    do_reset();
    for (int i = 0; i < 16; i++) wr_reg(REG_CMD_DATA, 32'hC0DE_0000 + 32'(i));
    wr_reg(REG_CMD_DATA, 32'hDEAD_BEEF);
    rd_chk("B_status_full_ovf", REG_STATUS, 32'h0006_0010);
    cmd_axis_tready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("B_out%0d_tvalid", i), {31'b0, cmd_axis_tvalid_o}, 32'd1);
      chk($sformatf("B_out%0d_tdata", i), cmd_axis_tdata_o, 32'hC0DE_0000 + 32'(i));
      @(negedge clk);
    end
    chk("B_drained_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd0);
    cmd_axis_tready_i = 1'b0;
    rd_chk("B_status_ovf_sticky", REG_STATUS, 32'h0005_0000);
    wr_reg(REG_CONTROL, 32'h0000_0002);
    rd_chk("B_status_ovf_clr", REG_STATUS, 32'h0001_0000);

    // C: push into a full FIFO on the same edge as a pop
    do_reset();
    for (int i = 0; i < 16; i++) wr_reg(REG_CMD_DATA, 32'hC0DE_0100 + 32'(i));
    bus_op(1'b1, REG_CMD_DATA, 32'h1234_5678, 1'b1, d);
    cmd_axis_tready_i = 1'b0;
    rd_chk("C_status_full_no_ovf", REG_STATUS, 32'h0002_0010);
    cmd_axis_tready_i = 1'b1;
    for (int i = 1; i < 17; i++) begin
      chk($sformatf("C_out%0d_tdata", i), cmd_axis_tdata_o,
          (i == 16) ? 32'h1234_5678 : 32'hC0DE_0100 + 32'(i));
      @(negedge clk);
    end
    chk("C_drained_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd0);
    cmd_axis_tready_i = 1'b0;

    // D: flush with head stalled keeps it; flush with head accepted empties
    do_reset();
    for (int i = 0; i < 5; i++) wr_reg(REG_CMD_DATA, 32'hF00D_0000 + 32'(i));
    wr_reg(REG_CONTROL, 32'h0000_0001);
    chk("D_keep_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd1);
    chk("D_keep_tdata", cmd_axis_tdata_o, 32'hF00D_0000);
    rd_chk("D_keep_status", REG_STATUS, 32'h0000_0001);
    for (int i = 0; i < 4; i++) wr_reg(REG_CMD_DATA, 32'hBEE0_0000 + 32'(i));
    rd_chk("D_refill_status", REG_STATUS, 32'h0000_0005);
    bus_op(1'b1, REG_CONTROL, 32'h0000_0001, 1'b1, d);
    cmd_axis_tready_i = 1'b0;
    chk("D_flush_pop_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd0);
    rd_chk("D_flush_pop_status", REG_STATUS, 32'h0001_0000);

    // E: low-water interrupt timing
    do_reset();
    wr_reg(REG_CONTROL, 32'h0000_0004);
    for (int i = 0; i < 6; i++) wr_reg(REG_CMD_DATA, 32'h0E00_0000 + 32'(i));
    chk("E_irq_at6", {31'b0, irq_o}, 32'd0);
    cmd_axis_tready_i = 1'b1;
    repeat (2) @(negedge clk);
    cmd_axis_tready_i = 1'b0;
    chk("E_irq_level4_same_cycle", {31'b0, irq_o}, 32'd0);
    @(negedge clk);
    chk("E_irq_rise", {31'b0, irq_o}, 32'd1);
    wr_reg(REG_CMD_DATA, 32'h0E00_00FF);
    chk("E_irq_push_same_cycle", {31'b0, irq_o}, 32'd1);
    @(negedge clk);
    chk("E_irq_fall", {31'b0, irq_o}, 32'd0);
    rd_chk("E_status", REG_STATUS, 32'h0000_0005);

    // F: asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 8; i++) wr_reg(REG_CMD_DATA, 32'h0F00_0000 + 32'(i));
    chk("F_pre_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd1);
    @(negedge clk);
    #2 reset_n_i = 1'b0;
    #1;
    chk("F_async_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'd0);
    chk("F_async_tdata", cmd_axis_tdata_o, 32'd0);
    chk("F_async_ack", {31'b0, ack_o}, 32'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    rd_chk("F_status_after", REG_STATUS, 32'h0001_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
